// File: rtl/gerenciador_servos_uc.sv
// gerenciador_servos_uc - control unit for the servo manager datapath.
//
// Runs one movement command at a time for three servos: peteleco (360 deg
// flicker), tampa (180 deg lid) and base (180 deg turntable). For each
// command it clears and enables the datapath timers, toggles the lid/base
// position flip-flops and drives the flicker direction. It then waits for
// the matching fim_servo_* and reports completion with a one-cycle pronto.
// A watchdog moves the FSM to ERRO if a timer never finishes.
//
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   iniciar, comando[1:0]   command strobe and code (00 PET, 01 TAMPA,
//                           10 BASE, 11 GIRA_FACE); sampled in ESPERA/ERRO
//   fim_servo_*             datapath timer done flags
//   ativa_*                 servo phase active (level)
//   zera_servo_*            one-cycle timer clear
//   conta_servo_*           timer count enable
//   gira                    flicker position
//   shifta_servo_tampa/base one-cycle position toggle
//   ocupado, pronto, erro   busy, completion pulse, sticky watchdog flag
//   db_estado[3:0]          current state code
module gerenciador_servos_uc #(
  parameter int TIMEOUT = 60000000,
  parameter int TW      = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] comando,
  input  logic       fim_servo_peteleco,
  input  logic       fim_servo_tampa,
  input  logic       fim_servo_base,
  output logic       ativa_peteleco,
  output logic       ativa_tampa,
  output logic       ativa_base,
  output logic       zera_servo_peteleco,
  output logic       zera_servo_tampa,
  output logic       zera_servo_base,
  output logic       conta_servo_peteleco,
  output logic       conta_servo_tampa,
  output logic       conta_servo_base,
  output logic       gira,
  output logic       shifta_servo_tampa,
  output logic       shifta_servo_base,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    ESPERA      = 4'h1,
    PET_IDA     = 4'h2,
    PET_IDA_W   = 4'h3,
    PET_VOLTA   = 4'h4,
    PET_VOLTA_W = 4'h5,
    T_SH        = 4'h6,
    T_W         = 4'h7,
    B_SH        = 4'h8,
    B_W         = 4'h9,
    C_T1_SH     = 4'hA,
    C_T1_W      = 4'hB,
    C_B_SH      = 4'hC,
    C_B_W       = 4'hD,
    FIM         = 4'hE,
    ERRO        = 4'hF
  } estado_t;

  localparam logic [TW-1:0] WD_LIM = TW'(TIMEOUT - 1);

  estado_t       estado_q, estado_d;
  // Set while T_SH/T_W are being used as the second lid phase of GIRA_FACE
  // (C_T2_SH/C_T2_W). Both paths end in FIM, so it only tags the phase.
  logic          fase_q, fase_d;
  logic [TW-1:0] wd_q, wd_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      fase_q   <= 1'b0;
      wd_q     <= '0;
    end else begin
      estado_q <= estado_d;
      fase_q   <= fase_d;
      wd_q     <= wd_d;
    end
  end

  // Next state. The watchdog counts only in wait states and is zero
  // everywhere else, so every shift state starts the wait from 0.
  // A fim sampled on the timeout cycle takes priority over the error.
  always_comb begin
    estado_d = estado_q;
    fase_d   = fase_q;
    wd_d     = '0;
    unique case (estado_q)
      INICIAL: begin
        estado_d = ESPERA;
        fase_d   = 1'b0;
      end
      ESPERA, ERRO: begin
        fase_d = 1'b0;
        if (iniciar) begin
          unique case (comando)
            2'b00:   estado_d = PET_IDA;
            2'b01:   estado_d = T_SH;
            2'b10:   estado_d = B_SH;
            default: estado_d = C_T1_SH;
          endcase
        end
      end
      PET_IDA:   estado_d = PET_IDA_W;
      PET_VOLTA: estado_d = PET_VOLTA_W;
      T_SH:      estado_d = T_W;
      B_SH:      estado_d = B_W;
      C_T1_SH:   estado_d = C_T1_W;
      C_B_SH:    estado_d = C_B_W;
      PET_IDA_W: begin
        if (fim_servo_peteleco)  estado_d = PET_VOLTA;
        else if (wd_q == WD_LIM) estado_d = ERRO;
        else                     wd_d = wd_q + TW'(1);
      end
      PET_VOLTA_W: begin
        if (fim_servo_peteleco)  estado_d = FIM;
        else if (wd_q == WD_LIM) estado_d = ERRO;
        else                     wd_d = wd_q + TW'(1);
      end
      T_W: begin
        if (fim_servo_tampa)     estado_d = FIM;
        else if (wd_q == WD_LIM) estado_d = ERRO;
        else                     wd_d = wd_q + TW'(1);
      end
      B_W: begin
        if (fim_servo_base)      estado_d = FIM;
        else if (wd_q == WD_LIM) estado_d = ERRO;
        else                     wd_d = wd_q + TW'(1);
      end
      C_T1_W: begin
        if (fim_servo_tampa)     estado_d = C_B_SH;
        else if (wd_q == WD_LIM) estado_d = ERRO;
        else                     wd_d = wd_q + TW'(1);
      end
      C_B_W: begin
        if (fim_servo_base) begin
          estado_d = T_SH;
          fase_d   = 1'b1;
        end else if (wd_q == WD_LIM) begin
          estado_d = ERRO;
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end
      FIM: begin
        estado_d = ESPERA;
        fase_d   = 1'b0;
      end
      default: estado_d = INICIAL;
    endcase
  end

  // Moore output decode.
  always_comb begin
    ativa_peteleco       = 1'b0;
    ativa_tampa          = 1'b0;
    ativa_base           = 1'b0;
    zera_servo_peteleco  = 1'b0;
    zera_servo_tampa     = 1'b0;
    zera_servo_base      = 1'b0;
    conta_servo_peteleco = 1'b0;
    conta_servo_tampa    = 1'b0;
    conta_servo_base     = 1'b0;
    gira                 = 1'b0;
    shifta_servo_tampa   = 1'b0;
    shifta_servo_base    = 1'b0;
    ocupado              = 1'b1;
    pronto               = 1'b0;
    erro                 = 1'b0;
    unique case (estado_q)
      INICIAL, ESPERA: ocupado = 1'b0;
      ERRO: begin
        ocupado = 1'b0;
        erro    = 1'b1;
      end
      PET_IDA: begin
        ativa_peteleco      = 1'b1;
        zera_servo_peteleco = 1'b1;
        gira                = 1'b1;
      end
      PET_IDA_W: begin
        ativa_peteleco       = 1'b1;
        conta_servo_peteleco = 1'b1;
        gira                 = 1'b1;
      end
      PET_VOLTA: begin
        ativa_peteleco      = 1'b1;
        zera_servo_peteleco = 1'b1;
      end
      PET_VOLTA_W: begin
        ativa_peteleco       = 1'b1;
        conta_servo_peteleco = 1'b1;
      end
      T_SH, C_T1_SH: begin
        ativa_tampa        = 1'b1;
        zera_servo_tampa   = 1'b1;
        shifta_servo_tampa = 1'b1;
      end
      T_W, C_T1_W: begin
        ativa_tampa       = 1'b1;
        conta_servo_tampa = 1'b1;
      end
      B_SH, C_B_SH: begin
        ativa_base        = 1'b1;
        zera_servo_base   = 1'b1;
        shifta_servo_base = 1'b1;
      end
      B_W, C_B_W: begin
        ativa_base       = 1'b1;
        conta_servo_base = 1'b1;
      end
      FIM:     pronto = 1'b1;
      default: ocupado = 1'b0;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_gerenciador_servos_uc.sv
module tb_gerenciador_servos_uc;

  localparam int TO = 20;

  logic       clock = 1'b0;
  logic       reset, iniciar;
  logic [1:0] comando;
  logic       fim_servo_peteleco, fim_servo_tampa, fim_servo_base;
  logic       ativa_peteleco, ativa_tampa, ativa_base;
  logic       zera_servo_peteleco, zera_servo_tampa, zera_servo_base;
  logic       conta_servo_peteleco, conta_servo_tampa, conta_servo_base;
  logic       gira, shifta_servo_tampa, shifta_servo_base;
  logic       ocupado, pronto, erro;
  logic [3:0] db_estado;

  int checks = 0;
  int failures = 0;

  gerenciador_servos_uc #(.TIMEOUT(TO), .TW(5)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .comando(comando),
    .fim_servo_peteleco(fim_servo_peteleco), .fim_servo_tampa(fim_servo_tampa),
    .fim_servo_base(fim_servo_base),
    .ativa_peteleco(ativa_peteleco), .ativa_tampa(ativa_tampa), .ativa_base(ativa_base),
    .zera_servo_peteleco(zera_servo_peteleco), .zera_servo_tampa(zera_servo_tampa),
    .zera_servo_base(zera_servo_base),
    .conta_servo_peteleco(conta_servo_peteleco), .conta_servo_tampa(conta_servo_tampa),
    .conta_servo_base(conta_servo_base),
    .gira(gira), .shifta_servo_tampa(shifta_servo_tampa), .shifta_servo_base(shifta_servo_base),
    .ocupado(ocupado), .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Behavioural datapath: timers cleared by zera, counting while conta;
  // fim raised once the count reaches the threshold (4 -> 5th wait cycle).
  int cnt_p, cnt_t, cnt_b;
  int thr_p = 4, thr_t = 4, thr_b = 4;
  logic lid_pos, base_pos;

  always @(posedge clock) begin
    if (reset) begin
      cnt_p <= 0; cnt_t <= 0; cnt_b <= 0;
      lid_pos <= 1'b0; base_pos <= 1'b0;
    end else begin
      if (zera_servo_peteleco) cnt_p <= 0; else if (conta_servo_peteleco) cnt_p <= cnt_p + 1;
      if (zera_servo_tampa)    cnt_t <= 0; else if (conta_servo_tampa)    cnt_t <= cnt_t + 1;
      if (zera_servo_base)     cnt_b <= 0; else if (conta_servo_base)     cnt_b <= cnt_b + 1;
      if (shifta_servo_tampa) lid_pos <= ~lid_pos;
      if (shifta_servo_base)  base_pos <= ~base_pos;
    end
  end

  assign fim_servo_peteleco = conta_servo_peteleco && (cnt_p >= thr_p);
  assign fim_servo_tampa    = conta_servo_tampa    && (cnt_t >= thr_t);
  assign fim_servo_base     = conta_servo_base     && (cnt_b >= thr_b);

  logic [14:0] obs;
  assign obs = {ativa_peteleco, ativa_tampa, ativa_base,
                zera_servo_peteleco, zera_servo_tampa, zera_servo_base,
                conta_servo_peteleco, conta_servo_tampa, conta_servo_base,
                gira, shifta_servo_tampa, shifta_servo_base, ocupado, pronto, erro};

  localparam logic [14:0] AP = 15'h4000, AT = 15'h2000, AB = 15'h1000;
  localparam logic [14:0] ZP = 15'h0800, ZT = 15'h0400, ZB = 15'h0200;
  localparam logic [14:0] CP = 15'h0100, CT = 15'h0080, CB = 15'h0040;
  localparam logic [14:0] GI = 15'h0020, ST = 15'h0010, SB = 15'h0008;
  localparam logic [14:0] OC = 15'h0004, PR = 15'h0002, ER = 15'h0001;

  // Expected Moore outputs for each visible state code.
  function automatic logic [14:0] exp_outs(input logic [3:0] s);
    case (s)
      4'h2:        return AP | ZP | GI | OC;
      4'h3:        return AP | CP | GI | OC;
      4'h4:        return AP | ZP | OC;
      4'h5:        return AP | CP | OC;
      4'h6, 4'hA:  return AT | ZT | ST | OC;
      4'h7, 4'hB:  return AT | CT | OC;
      4'h8, 4'hC:  return AB | ZB | SB | OC;
      4'h9, 4'hD:  return AB | CB | OC;
      4'hE:        return OC | PR;
      4'hF:        return ER;
      default:     return 15'h0;
    endcase
  endfunction

  logic [3:0] exp_q[$];

  // Expected state trace of a command with n wait cycles per timer phase.
  task automatic push_seq(input logic [1:0] cmd, input int n);
    case (cmd)
      2'b00: begin
        exp_q.push_back(4'h2); repeat (n) exp_q.push_back(4'h3);
        exp_q.push_back(4'h4); repeat (n) exp_q.push_back(4'h5);
      end
      2'b01: begin
        exp_q.push_back(4'h6); repeat (n) exp_q.push_back(4'h7);
      end
      2'b10: begin
        exp_q.push_back(4'h8); repeat (n) exp_q.push_back(4'h9);
      end
      default: begin
        exp_q.push_back(4'hA); repeat (n) exp_q.push_back(4'hB);
        exp_q.push_back(4'hC); repeat (n) exp_q.push_back(4'hD);
        exp_q.push_back(4'h6); repeat (n) exp_q.push_back(4'h7);
      end
    endcase
    exp_q.push_back(4'hE);
    exp_q.push_back(4'h1);
  endtask

  task automatic test_reset;
    reset = 1'b1; iniciar = 1'b0; comando = 2'b00;
    repeat (3) @(negedge clock);
    checks++;
    if (db_estado !== 4'h0 || obs !== 15'h0) begin
      failures++;
      $display("FAIL reset_state state=%h outs=%h required state=0 outs=0000", db_estado, obs);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h1 || obs !== 15'h0) begin
      failures++;
      $display("FAIL reset_to_espera state=%h outs=%h required state=1 outs=0000", db_estado, obs);
    end
  endtask

  task automatic test_tampa;
    logic lid0; int pr; logic [3:0] e;
    lid0 = lid_pos; pr = 0;
    push_seq(2'b01, 5);
    @(negedge clock); iniciar = 1'b1; comando = 2'b01;
    while (exp_q.size() > 0) begin
      @(negedge clock); iniciar = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (db_estado !== e || obs !== exp_outs(e)) begin
        failures++;
        $display("FAIL tampa_seq state=%h outs=%h required state=%h outs=%h", db_estado, obs, e, exp_outs(e));
      end
      if (pronto) pr++;
    end
    checks++;
    if (pr !== 1) begin failures++; $display("FAIL tampa_pronto count=%0d required=1", pr); end
    checks++;
    if (lid_pos !== ~lid0) begin failures++; $display("FAIL tampa_lid pos=%b required=%b", lid_pos, ~lid0); end
  endtask

  task automatic test_peteleco;
    int pr, zp; logic [3:0] e;
    pr = 0; zp = 0;
    push_seq(2'b00, 5);
    @(negedge clock); iniciar = 1'b1; comando = 2'b00;
    while (exp_q.size() > 0) begin
      @(negedge clock); iniciar = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (db_estado !== e || obs !== exp_outs(e)) begin
        failures++;
        $display("FAIL peteleco_seq state=%h outs=%h required state=%h outs=%h", db_estado, obs, e, exp_outs(e));
      end
      if (pronto) pr++;
      if (zera_servo_peteleco) zp++;
    end
    checks++;
    if (pr !== 1 || zp !== 2) begin
      failures++;
      $display("FAIL peteleco_pulses pronto=%0d zera=%0d required pronto=1 zera=2", pr, zp);
    end
  endtask

  task automatic test_gira_face;
    logic lid0, base0; int ord; logic [3:0] e;
    lid0 = lid_pos; base0 = base_pos; ord = 0;
    push_seq(2'b11, 5);
    @(negedge clock); iniciar = 1'b1; comando = 2'b11;
    while (exp_q.size() > 0) begin
      @(negedge clock); iniciar = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (db_estado !== e || obs !== exp_outs(e)) begin
        failures++;
        $display("FAIL gira_face_seq state=%h outs=%h required state=%h outs=%h", db_estado, obs, e, exp_outs(e));
      end
      if (shifta_servo_tampa) ord = ord * 4 + 1;
      if (shifta_servo_base)  ord = ord * 4 + 2;
    end
    // tampa, base, tampa encoded base-4 as 1,2,1
    checks++;
    if (ord !== 25) begin failures++; $display("FAIL gira_face_order code=%0d required=25", ord); end
    checks++;
    if (lid_pos !== lid0 || base_pos !== ~base0) begin
      failures++;
      $display("FAIL gira_face_pos lid=%b base=%b required lid=%b base=%b", lid_pos, base_pos, lid0, ~base0);
    end
  endtask

  task automatic test_busy_ignore;
    int pr, sb; bit sent; logic [3:0] e;
    pr = 0; sb = 0; sent = 0;
    push_seq(2'b01, 5);
    @(negedge clock); iniciar = 1'b1; comando = 2'b01;
    while (exp_q.size() > 0) begin
      @(negedge clock); iniciar = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (db_estado !== e || obs !== exp_outs(e)) begin
        failures++;
        $display("FAIL busy_seq state=%h outs=%h required state=%h outs=%h", db_estado, obs, e, exp_outs(e));
      end
      if (pronto) pr++;
      if (shifta_servo_base) sb++;
      if (e == 4'h7 && !sent) begin iniciar = 1'b1; comando = 2'b10; sent = 1; end
    end
    checks++;
    if (pr !== 1 || sb !== 0) begin
      failures++;
      $display("FAIL busy_ignore pronto=%0d base_shifts=%0d required pronto=1 base_shifts=0", pr, sb);
    end
  endtask

  task automatic test_watchdog;
    logic [3:0] e;
    thr_b = 1000;
    exp_q.push_back(4'h8);
    repeat (TO) exp_q.push_back(4'h9);
    repeat (3) exp_q.push_back(4'hF);
    @(negedge clock); iniciar = 1'b1; comando = 2'b10;
    while (exp_q.size() > 0) begin
      @(negedge clock); iniciar = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (db_estado !== e || obs !== exp_outs(e)) begin
        failures++;
        $display("FAIL watchdog_seq state=%h outs=%h required state=%h outs=%h", db_estado, obs, e, exp_outs(e));
      end
    end
    checks++;
    if (erro !== 1'b1) begin failures++; $display("FAIL watchdog_erro erro=%b required=1", erro); end
    thr_b = 4;
    // Recovery from ERRO starts the new command directly.
    test_tampa();
    checks++;
    if (erro !== 1'b0) begin failures++; $display("FAIL watchdog_clear erro=%b required=0", erro); end
    // fim arrives on the very cycle the watchdog would fire.
    thr_b = TO - 1;
    push_seq(2'b10, TO);
    @(negedge clock); iniciar = 1'b1; comando = 2'b10;
    while (exp_q.size() > 0) begin
      @(negedge clock); iniciar = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (db_estado !== e || obs !== exp_outs(e)) begin
        failures++;
        $display("FAIL fim_wins_seq state=%h outs=%h required state=%h outs=%h", db_estado, obs, e, exp_outs(e));
      end
    end
    thr_b = 4;
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    @(negedge clock); iniciar = 1'b1; comando = 2'b11;
    @(negedge clock); iniciar = 1'b0;
    while (db_estado !== 4'hD && n < 40) begin @(negedge clock); n++; end
    checks++;
    if (db_estado !== 4'hD) begin
      failures++;
      $display("FAIL reset_mid_reach state=%h required=d", db_estado);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h0 || obs !== 15'h0 || lid_pos !== 1'b0 || base_pos !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_abort state=%h outs=%h lid=%b base=%b required state=0 outs=0000 lid=0 base=0",
               db_estado, obs, lid_pos, base_pos);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h1 || obs !== 15'h0) begin
      failures++;
      $display("FAIL reset_mid_espera state=%h outs=%h required state=1 outs=0000", db_estado, obs);
    end
    test_tampa();
  endtask

  initial begin
    test_reset();
    test_tampa();
    test_peteleco();
    test_gira_face();
    test_busy_ignore();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "simulation time limit");
  end

endmodule
